// File: rtl/mem_bus.sv
// Single-port CPU memory bus: RAM, read-only switch port, write-only LED port, sticky error flag.
// Optional MEM_BUS_SW_SYNC_EN inserts a two-flop synchronizer on the switch inputs.
module mem_bus #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RAM_AW     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mem_cmd,
    input  logic [8:0]            mem_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rd_valid,
    input  logic [7:0]            sw,
    output logic [7:0]            led,
    output logic                  bus_err
);

    localparam int unsigned Depth = 1 << RAM_AW;

    typedef enum logic [1:0] {
        CmdNone  = 2'b00,
        CmdRead  = 2'b01,
        CmdWrite = 2'b10,
        CmdIll   = 2'b11
    } cmd_e;

    logic [DATA_WIDTH-1:0] ram_q [Depth];
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [7:0]            led_q, led_d;
    logic                  bus_err_q, bus_err_d;
    logic                  ram_we;
    logic [7:0]            sw_value;
    logic [DATA_WIDTH-1:0] sw_word;
    logic [RAM_AW-1:0]     ram_idx;
    logic                  is_ram, is_sw, is_led;

`ifdef MEM_BUS_SW_SYNC_EN
    logic [7:0] sw_s1_q, sw_s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
        end
    end

    assign sw_value = sw_s2_q;
`else
    assign sw_value = sw;
`endif

    always_comb begin
        sw_word      = '0;
        sw_word[7:0] = sw_value;
    end

    assign ram_idx = mem_addr[RAM_AW-1:0];
    assign is_ram  = ~mem_addr[8];
    assign is_sw   = (mem_addr == 9'h140);
    assign is_led  = (mem_addr == 9'h100);

    always_comb begin
        read_data_d = read_data_q;
        rd_valid_d  = 1'b0;
        led_d       = led_q;
        bus_err_d   = bus_err_q;
        ram_we      = 1'b0;
        case (cmd_e'(mem_cmd))
            CmdRead: begin
                rd_valid_d = 1'b1;
                if (is_ram) begin
                    read_data_d = ram_q[ram_idx];
                end else if (is_sw) begin
                    read_data_d = sw_word;
                end else begin
                    // LED port and unmapped space read back as zero
                    read_data_d = '0;
                    bus_err_d   = 1'b1;
                end
            end
            CmdWrite: begin
                if (is_ram) begin
                    ram_we = 1'b1;
                end else if (is_led) begin
                    led_d = write_data[7:0];
                end else begin
                    bus_err_d = 1'b1;
                end
            end
            CmdIll: begin
                bus_err_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q <= '0;
            rd_valid_q  <= 1'b0;
            led_q       <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            rd_valid_q  <= rd_valid_d;
            led_q       <= led_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // RAM has no reset so its contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram_q[ram_idx] <= write_data;
        end
    end

    assign read_data = read_data_q;
    assign rd_valid  = rd_valid_q;
    assign led       = led_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_bus.sv
// Directed, table-driven bench for mem_bus plus hand-written reset and switch-sync sequences.
module tb_mem_bus;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_valid;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        bus_err;

    int n_cmp;
    int n_bad;

    mem_bus #(
        .DATA_WIDTH(16),
        .RAM_AW    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .write_data(write_data),
        .read_data (read_data),
        .rd_valid  (rd_valid),
        .sw        (sw),
        .led       (led),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        exp_rv;
        logic [7:0]  exp_led;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] rd, input logic rv,
                           input logic [7:0] ld, input logic er);
        chk({tag, ".read_data"}, read_data, rd);
        chk({tag, ".rd_valid"}, {15'd0, rd_valid}, {15'd0, rv});
        chk({tag, ".led"}, {8'd0, led}, {8'd0, ld});
        chk({tag, ".bus_err"}, {15'd0, bus_err}, {15'd0, er});
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        mem_cmd    = 2'b00;
        mem_addr   = '0;
        write_data = '0;
        sw         = 8'h5A;

        //          cmd    addr    wd        rd       rv    led    err
        vecs[0]  = '{2'b10, 9'h005, 16'hD2A5, 16'h0000, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{2'b01, 9'h005, 16'h0000, 16'hD2A5, 1'b1, 8'h00, 1'b0};
        vecs[2]  = '{2'b00, 9'h005, 16'h0000, 16'hD2A5, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{2'b10, 9'h010, 16'h1234, 16'hD2A5, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{2'b01, 9'h010, 16'h0000, 16'h1234, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{2'b01, 9'h005, 16'h0000, 16'hD2A5, 1'b1, 8'h00, 1'b0};
        vecs[6]  = '{2'b01, 9'h005, 16'h0000, 16'hD2A5, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{2'b10, 9'h100, 16'h12C3, 16'hD2A5, 1'b0, 8'hC3, 1'b0};
        vecs[8]  = '{2'b01, 9'h140, 16'h0000, 16'h005A, 1'b1, 8'hC3, 1'b0};
        vecs[9]  = '{2'b01, 9'h100, 16'h0000, 16'h0000, 1'b1, 8'hC3, 1'b1};
        vecs[10] = '{2'b10, 9'h140, 16'hFFFF, 16'h0000, 1'b0, 8'hC3, 1'b1};
        vecs[11] = '{2'b10, 9'h1FF, 16'h5555, 16'h0000, 1'b0, 8'hC3, 1'b1};
        vecs[12] = '{2'b11, 9'h005, 16'h0000, 16'h0000, 1'b0, 8'hC3, 1'b1};
        vecs[13] = '{2'b01, 9'h005, 16'h0000, 16'hD2A5, 1'b1, 8'hC3, 1'b1};
        vecs[14] = '{2'b01, 9'h1AB, 16'h0000, 16'h0000, 1'b1, 8'hC3, 1'b1};

        #30;
        chk_all("reset", 16'h0000, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].cmd, vecs[i].addr, vecs[i].wd);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_rv,
                    vecs[i].exp_led, vecs[i].exp_err);
        end

        // Switch change followed immediately by reads of the switch port
        sw = 8'hA5;
`ifdef MEM_BUS_SW_SYNC_EN
        step(2'b01, 9'h140, 16'h0000);
        chk("sw_e1", read_data, 16'h005A);
        step(2'b01, 9'h140, 16'h0000);
        chk("sw_e2", read_data, 16'h005A);
`else
        step(2'b01, 9'h140, 16'h0000);
        chk("sw_e1", read_data, 16'h00A5);
        step(2'b01, 9'h140, 16'h0000);
        chk("sw_e2", read_data, 16'h00A5);
`endif
        step(2'b01, 9'h140, 16'h0000);
        chk("sw_e3", read_data, 16'h00A5);

        // RAM retention across reset, and commands ignored while reset is high
        step(2'b10, 9'h0FF, 16'hBEEF);
        reset = 1'b1;
        #1;
        chk_all("rst_async", 16'h0000, 1'b0, 8'h00, 1'b0);
        step(2'b01, 9'h0FF, 16'h0000);
        chk("rst_ignore.rd_valid", {15'd0, rd_valid}, 16'h0000);
        step(2'b10, 9'h0FF, 16'h1111);
        #3;
        reset = 1'b0;
        step(2'b01, 9'h0FF, 16'h0000);
        chk_all("retain", 16'hBEEF, 1'b1, 8'h00, 1'b0);

        // Reset in the cycle after a READ kills the rd_valid pulse
        step(2'b01, 9'h005, 16'h0000);
        chk("pre_kill.read_data", read_data, 16'hD2A5);
        reset = 1'b1;
        #1;
        chk("kill.rd_valid", {15'd0, rd_valid}, 16'h0000);
        chk("kill.read_data", read_data, 16'h0000);
        #3;
        reset = 1'b0;

        // Illegal command from a clean error state; flag is sticky
        step(2'b11, 9'h005, 16'h0000);
        chk_all("illegal", 16'h0000, 1'b0, 8'h00, 1'b1);
        step(2'b00, 9'h000, 16'h0000);
        chk("sticky1.bus_err", {15'd0, bus_err}, 16'h0001);
        step(2'b01, 9'h005, 16'h0000);
        chk_all("sticky2", 16'hD2A5, 1'b1, 8'h00, 1'b1);
        step(2'b00, 9'h000, 16'h0000);
        chk_all("none_hold", 16'hD2A5, 1'b0, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus.md
MEM_BUS -- requirements
Module: mem_bus

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width of data paths and RAM.
REQ-002 SHALL have parameter RAM_AW, default 8, RAM address bits (depth 2^RAM_AW = 256 words).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port mem_cmd, input, 2, CPU command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 illegal.
REQ-006 SHALL have port mem_addr, input, 9, CPU byte-free word address.
REQ-007 SHALL have port write_data, input, DATA_WIDTH, store data from the CPU datapath output.
REQ-008 SHALL have port read_data, output, DATA_WIDTH, registered read data to the CPU instruction/data input.
REQ-009 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying read_data.
REQ-010 SHALL have port sw, input, 8, board switches.
REQ-011 SHALL have port led, output, 8, registered board LEDs.
REQ-012 SHALL have port bus_err, output, 1, sticky error flag.

Function
REQ-013 SHALL decode: mem_addr[8]=0 -> RAM word mem_addr[RAM_AW-1:0]; 9'h140 -> switch port (read-only); 9'h100 -> LED port (write-only); any other address unmapped.
REQ-014 SHALL, on READ at cycle N, present the addressed data on read_data and assert rd_valid in cycle N+1 (latency 1); read_data holds its value until the next READ.
REQ-015 SHALL return {8'h00, sw_value} for a READ of 9'h140.
REQ-016 SHALL, on WRITE to RAM, store write_data at the rising edge ending the command cycle; a READ of the same address in the next cycle returns the new value.
REQ-017 SHALL, on WRITE to 9'h100, load led <= write_data[7:0] at that edge.
REQ-018 SHALL treat a command held for k consecutive cycles as k independent accesses (k pulses of rd_valid for READ; idempotent repeated writes).
REQ-019 SHALL, on READ of 9'h100 or any unmapped address, return 0 with rd_valid asserted and set bus_err.
REQ-020 SHALL, on WRITE to 9'h140 or any unmapped address, modify no state except setting bus_err.
REQ-021 SHALL, on mem_cmd 2'b11, perform no access, hold rd_valid low, and set bus_err.
REQ-022 SHALL keep bus_err set until reset; no other event clears it.
REQ-023 SHALL on NONE leave RAM, led, read_data unchanged and drive rd_valid low.

Reset
REQ-024 SHALL on reset assertion immediately force read_data=0, rd_valid=0, led=0, bus_err=0, and clear synchronizer flops.
REQ-025 SHALL NOT clear RAM contents on reset; RAM content is preserved across reset.
REQ-026 SHALL ignore mem_cmd while reset is high; the first access is accepted at the first rising edge after deassertion.
REQ-027 SHALL, if reset asserts in the cycle after a READ, suppress that READ's rd_valid pulse.

Configuration
REQ-028 SHALL, with macro MEM_BUS_SW_SYNC_EN defined, pass sw through a two-flop synchronizer, so a switch change is visible to reads issued 2 cycles later (read_data 3 cycles later).
REQ-029 SHALL, without MEM_BUS_SW_SYNC_EN, sample sw directly in the read path (change visible to a READ in the same cycle).

Verification
REQ-030 SHALL verify: reset high 30 ns then low -> read_data=0, rd_valid=0, led=0, bus_err=0.
REQ-031 SHALL verify: WRITE 9'h005 data 16'hD2A5, then READ 9'h005 next cycle -> read_data=16'hD2A5, rd_valid=1 exactly one cycle later.
REQ-032 SHALL verify: WRITE 9'h100 data 16'h12C3 -> led=8'hC3; READ 9'h100 -> read_data=0, bus_err=1.
REQ-033 SHALL verify: sw=8'h5A, READ 9'h140 (after sync delay when MEM_BUS_SW_SYNC_EN) -> read_data=16'h005A.
REQ-034 SHALL verify: mem_cmd=2'b11 at 9'h005 -> RAM[5] unchanged, rd_valid=0, bus_err=1 and stays 1 until reset.
REQ-035 SHALL verify: WRITE 9'h0FF data 16'hBEEF, reset pulse, READ 9'h0FF -> read_data=16'hBEEF (RAM retained).
